// File: rtl/bfs_axi_pkg.sv
// Shared definitions for the BFS AXI read masters: FSM encoding and beat geometry.
package bfs_axi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AR_WAIT = 2'd1,
        AR_REQ  = 2'd2,
        DATA    = 2'd3
    } rd_state_e;

    localparam int AXI_BEAT_BYTES = 8;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered write and a free-entry count.
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             wr, rd;

    assign rd    = rd_en && (count != '0);
    assign wr    = wr_en && ((count != DEPTH_W) || rd);
    assign empty = (count == '0);
    assign free  = DEPTH_W - count;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (wr && !rd)      count <= count + 1'b1;
            else if (!wr && rd) count <= count - 1'b1;
        end
    end

    // Storage is not reset; pointer reset is what discards contents.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/axi_read_requester.sv
// Splits a (address, word count) command into single-outstanding fixed-length AR bursts
// and streams the trimmed data out of a local FIFO. Option: AXI_RD_REQ_LAST_CHECK_EN.
module axi_read_requester
    import bfs_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int BURST_LEN      = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]      cmd_words,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                      m_axi_rvalid,
    input  logic                      m_axi_rlast,
    output logic                      m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(FIFO_DEPTH) + 2;
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * AXI_BEAT_BYTES);

    rd_state_e                 state, state_nx;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]      remaining, rem_after;
    logic [OW-1:0]             open_cmds, open_nx;
    logic [FW-1:0]             fifo_free;
    logic [AXI_DATA_WIDTH:0]   fifo_rd;
    logic                      fifo_empty, space, cmd_acc, ar_hs, beat, push, burst_end, pop, last_pop;

    assign cmd_ready     = (state == IDLE);
    assign cmd_acc       = cmd_valid && cmd_ready;
    assign space         = fifo_free >= FW'(BURST_LEN);
    assign m_axi_arvalid = (state == AR_REQ) || ((state == AR_WAIT) && space);
    assign m_axi_araddr  = addr;
    assign m_axi_rready  = (state == DATA);
    assign ar_hs         = m_axi_arvalid && m_axi_arready;
    assign beat          = m_axi_rvalid && m_axi_rready;
    assign push          = beat && (remaining != '0);
    assign burst_end     = beat && m_axi_rlast;
    assign rem_after     = push ? remaining - CNT_WIDTH'(1) : remaining;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd[AXI_DATA_WIDTH-1:0];
    assign out_last  = out_valid && fifo_rd[AXI_DATA_WIDTH];
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && out_last;
    assign open_nx   = open_cmds + OW'(cmd_acc && (cmd_words != '0)) - OW'(last_pop);

    // AR_WAIT can hand off directly to DATA when space exists and arready is already up.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_acc && (cmd_words != '0)) state_nx = AR_WAIT;
            AR_WAIT: if (space) state_nx = m_axi_arready ? DATA : AR_REQ;
            AR_REQ:  if (m_axi_arready) state_nx = DATA;
            DATA:    if (burst_end) state_nx = (rem_after != '0) ? AR_WAIT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            open_cmds <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            open_cmds <= open_nx;
            busy      <= cmd_acc || (open_nx != '0);
            if (cmd_acc) begin
                addr      <= cmd_addr & ~AXI_ADDR_WIDTH'(AXI_BEAT_BYTES - 1);
                remaining <= cmd_words;
            end else begin
                remaining <= rem_after;
                if (burst_end) addr <= addr + BURST_BYTES;
            end
        end
    end

`ifdef AXI_RD_REQ_LAST_CHECK_EN
    localparam int BW = $clog2(BURST_LEN) + 1;
    logic [BW-1:0] beat_cnt;

    // beat_cnt saturates at BURST_LEN so overlong bursts flag once and keep draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (ar_hs)
                beat_cnt <= '0;
            else if (beat && (beat_cnt != BW'(BURST_LEN)))
                beat_cnt <= beat_cnt + 1'b1;
            if (cmd_acc)
                err <= 1'b0;
            else if (beat && m_axi_rlast && (beat_cnt < BW'(BURST_LEN - 1)))
                err <= 1'b1;
            else if (beat && !m_axi_rlast && (beat_cnt == BW'(BURST_LEN - 1)))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({remaining == CNT_WIDTH'(1), m_axi_rdata}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

endmodule

// File: tb/tb_axi_read_requester.sv
// Bench for axi_read_requester: AXI read slave model, scoreboard queues for ARs and words.
module tb_axi_read_requester;

    localparam int AW = 32, DW = 64, BL = 8, CW = 16, FD = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] cmd_words;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic          m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, out_ready, busy, err;

    axi_read_requester #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
        .m_axi_rready(m_axi_rready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int            errors = 0, checks = 0;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] ar_q[$];
    int            ar_cnt = 0;
    bit            ready_en = 1'b1, ready_rnd = 1'b0;
    int            early_last = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            words;
        int            mode;   // 0 always ready, 1 random ready, 2 hold then release
        int            n_ars;
    } vec_t;
    vec_t vt[6];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Memory-side slave: one burst of BL beats per AR (or early_last beats when set).
    initial begin
        logic [AW-1:0] ba;
        int nb;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
        forever begin
            do begin
                @(negedge clk);
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                m_axi_arready = ($urandom_range(0, 3) != 0);
            end while (!(m_axi_arvalid && m_axi_arready));
            ba = m_axi_araddr;
            ar_cnt++;
            if (ar_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ar_extra got=%0h exp=none", ba);
            end else chk("ar_addr", 65'(ba), 65'(ar_q.pop_front()));
            nb = (early_last != 0) ? early_last : BL;
            early_last = 0;
            for (int b = 0; b < nb; b++) begin
                @(negedge clk);
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                while ($urandom_range(0, 3) == 0) @(negedge clk);
                chk("ar_single", 65'(m_axi_arvalid), 65'(0));
                chk("rready", 65'(m_axi_rready), 65'(1));
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = mem_word(ba + AW'(8 * b));
                m_axi_rlast  = (b == nb - 1);
            end
        end
    end

    // Consumer: pops words against the scoreboard, checks stall stability and busy fall.
    initial begin
        logic [DW:0] held, e;
        bit stall, want_idle;
        stall = 1'b0; want_idle = 1'b0; held = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0; want_idle = 1'b0; out_ready = 1'b0;
            end else begin
                if (want_idle) begin
                    chk("busy_fall", 65'(busy), 65'(0));
                    want_idle = 1'b0;
                end
                if (stall) begin
                    chk("hold_valid", 65'(out_valid), 65'(1));
                    chk("hold_data", 65'({out_last, out_data}), 65'(held));
                end
                out_ready = ready_en && (!ready_rnd || ($urandom_range(0, 1) == 1));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL word_extra got=%0h exp=none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", 65'(out_data), 65'(e[DW-1:0]));
                        chk("word_last", 65'(out_last), 65'(e[DW]));
                        if (out_last && exp_q.size() == 0) want_idle = 1'b1;
                    end
                end
                stall = out_valid && !out_ready;
                held  = {out_last, out_data};
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [CW-1:0] w);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout got=0 exp=1");
        end
        cmd_valid = 1'b1; cmd_addr = a; cmd_words = w;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        int t = 0;
        while ((busy || !cmd_ready) && t < n) begin @(negedge clk); t++; end
        if (t >= n) begin
            checks++; errors++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [AW-1:0] base;
        int a0;
        ready_rnd = (v.mode == 1);
        ready_en  = (v.mode != 2);
        base = v.addr & ~AW'(7);
        for (int k = 0; k < v.words; k++)
            exp_q.push_back({k == v.words - 1, mem_word(base + AW'(8 * k))});
        for (int k = 0; k < (v.words + BL - 1) / BL; k++)
            ar_q.push_back(base + AW'(8 * BL * k));
        a0 = ar_cnt;
        send_cmd(v.addr, CW'(v.words));
        chk("busy_rise", 65'(busy), 65'(1));
        chk("arvalid_latency", 65'(m_axi_arvalid), 65'(1));
        if (v.mode == 2) begin
            repeat (200) @(negedge clk);
            chk("stall_ar_count", 65'(ar_cnt - a0), 65'(2));
            chk("stall_arvalid", 65'(m_axi_arvalid), 65'(0));
            chk("stall_out_valid", 65'(out_valid), 65'(1));
            ready_en = 1'b1;
        end
        wait_idle(3000);
        chk("ar_count", 65'(ar_cnt - a0), 65'(v.n_ars));
        chk("words_left", 65'(exp_q.size()), 65'(0));
        chk("err_clean", 65'(err), 65'(0));
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_addr = '0; cmd_words = '0;
        vt[0] = '{32'h0000_1000,  8, 0, 1};
        vt[1] = '{32'h0000_2004, 11, 0, 2};
        vt[2] = '{32'h0000_3000, 40, 2, 5};
        vt[3] = '{32'hFFFF_FFC0, 16, 0, 2};
        vt[4] = '{32'h0000_4000,  1, 1, 1};
        vt[5] = '{32'h0000_5008, 17, 1, 3};

        repeat (3) @(negedge clk);
        chk("rst_arvalid", 65'(m_axi_arvalid), 65'(0));
        chk("rst_busy", 65'(busy), 65'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 65'(cmd_ready), 65'(1));
        chk("rst_araddr", 65'(m_axi_araddr), 65'(0));
        chk("rst_rready", 65'(m_axi_rready), 65'(0));
        chk("rst_out_valid", 65'(out_valid), 65'(0));
        chk("rst_out_last", 65'(out_last), 65'(0));
        chk("rst_err", 65'(err), 65'(0));

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Zero-word command: one-cycle busy pulse, no traffic.
        ready_en = 1'b1; ready_rnd = 1'b0;
        send_cmd(32'h0000_7000, '0);
        chk("zero_cmd_ready", 65'(cmd_ready), 65'(1));
        chk("zero_busy_pulse", 65'(busy), 65'(1));
        chk("zero_arvalid", 65'(m_axi_arvalid), 65'(0));
        @(negedge clk);
        chk("zero_busy_fall", 65'(busy), 65'(0));
        chk("zero_arvalid2", 65'(m_axi_arvalid), 65'(0));
        chk("zero_out_valid", 65'(out_valid), 65'(0));

`ifdef AXI_RD_REQ_LAST_CHECK_EN
        // Early rlast on beat 5: 5 words kept, remaining 3 come from the next burst address.
        early_last = 5;
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, mem_word(32'h6000 + AW'(8 * k))});
        for (int k = 0; k < 3; k++) exp_q.push_back({k == 2, mem_word(32'h6040 + AW'(8 * k))});
        ar_q.push_back(32'h6000);
        ar_q.push_back(32'h6040);
        send_cmd(32'h0000_6000, CW'(8));
        wait_idle(3000);
        chk("early_err_set", 65'(err), 65'(1));
        chk("early_words_left", 65'(exp_q.size()), 65'(0));
        exp_q.push_back({1'b1, mem_word(32'h1000)});
        ar_q.push_back(32'h1000);
        send_cmd(32'h0000_1000, CW'(1));
        chk("err_clear_on_accept", 65'(err), 65'(0));
        wait_idle(3000);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
